// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//
// Bus bundle around the fetch stage:
//   rom_addr_o / rom_data_i : combinational instruction ROM port. The ROM
//                             returns the word at rom_addr_o in the same cycle.
//   valid_o / ready_i       : decode handshake. A transfer happens in every
//                             cycle where valid_o && ready_i at the rising
//                             clock edge. valid_o may drop without a transfer
//                             (redirect flush). ready_i may be held high or
//                             low freely and never depends on anything else.
//   instr_o / pc_o          : head entry payload, meaningful while valid_o=1.
//
// Modports:
//   master : the fetch stage (drives address and handshake payload)
//   slave  : the ROM/decode side
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic [ADDR_W-1:0]  rom_addr_o;
  logic [INSTR_W-1:0] rom_data_i;
  logic               valid_o;
  logic               ready_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  pc_o;

  modport master (
    output rom_addr_o,
    input  rom_data_i,
    output valid_o,
    input  ready_i,
    output instr_o,
    output pc_o
  );

  modport slave (
    input  rom_addr_o,
    output rom_data_i,
    input  valid_o,
    output ready_i,
    input  instr_o,
    input  pc_o
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the PC, presents it to a combinational
// instruction ROM, and captures {pc, word} pairs into a DEPTH-entry FIFO that
// decode drains through the valid/ready handshake on the bus interface.
//
// Ports:
//   clk_i           : clock, rising edge
//   rst_ni          : asynchronous active-low reset
//   fetch_en_i      : permit fetching; when low the PC holds and nothing is pushed
//   redirect_i      : branch/jump taken; flushes the FIFO and loads target_i
//   target_i        : redirect byte address (low two bits dropped)
//   misaligned_o    : one-cycle pulse after a redirect whose target_i[1:0]!=0
//   out_of_range_o  : level, PC is outside the ROM window so fetching stops
//   dbg_count_o     : current FIFO occupancy, for observation only
//   bus (master)    : rom_addr_o/rom_data_i ROM port and
//                     valid_o/ready_i/instr_o/pc_o decode handshake
//
// Timing: a word fetched at PC p in cycle n is at the FIFO head (instr_o) in
// cycle n+1. With ready_i held high the stage sustains one word per cycle,
// because a full FIFO that is popped accepts a push in the same cycle.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INSTR_W   = 32,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [ADDR_W-1:0] ROM_BASE  = 32'hBFC00000,
  parameter int unsigned       ROM_BYTES = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         fetch_en_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            target_i,
  output logic                         misaligned_o,
  output logic                         out_of_range_o,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count_o,
  fetch_stage_if.master                bus
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
  // Last word-aligned byte address that still lies inside the ROM.
  localparam logic [ADDR_W-1:0] ROM_LAST = ROM_BASE + ADDR_W'(ROM_BYTES - 4);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0]  pc_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               misaligned_q;

  // FIFO storage carries no reset: the head outputs are forced to zero while
  // the FIFO is empty, so stale contents are never observable.
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic              in_range;
  logic              empty;
  logic              valid;
  logic              pop;
  logic              push;
  logic              has_room;
  logic [CNT_W-1:0]  count_d;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] redirect_pc;

  assign in_range = (pc_q >= ROM_BASE) && (pc_q <= ROM_LAST);
  assign empty    = (count_q == '0);

  // A redirect hides the head in the same cycle it arrives, so decode can
  // never consume an entry from the path being flushed.
  assign valid    = !empty && !redirect_i;
  assign pop      = valid && bus.ready_i;

  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign has_room = (count_q < DEPTH_C) || pop;
  assign push     = fetch_en_i && in_range && !redirect_i && has_room;

  // PC advance wraps modulo 2^ADDR_W; a wrap lands outside the ROM window and
  // is then caught by in_range.
  assign pc_next     = pc_q + ADDR_W'(4);
  assign redirect_pc = {target_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= ROM_BASE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else if (redirect_i) begin
      // Redirect overrides everything: flush, reload PC, flag misalignment.
      pc_q         <= redirect_pc;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      misaligned_q <= (target_i[1:0] != 2'b00);
    end else begin
      misaligned_q <= 1'b0;
      count_q      <= count_d;
      if (push) begin
        pc_q     <= pc_next;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= bus.rom_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rom_addr_o = pc_q;
  assign bus.valid_o    = valid;
  assign bus.instr_o    = empty ? '0 : instr_mem[rd_ptr_q];
  assign bus.pc_o       = empty ? '0 : pc_mem[rd_ptr_q];

  assign misaligned_o   = misaligned_q;
  assign out_of_range_o = !in_range;
  assign dbg_count_o    = count_q;

endmodule
